// File: rtl/rf_mp_pkg.sv
// Shared constants and the byte-merge helper for the rf_mp register file.
// Word arguments are sized for the widest supported register; callers zero-extend and truncate.
package rf_mp_pkg;

    localparam int RF_DEF_WIDTH    = 32;
    localparam int RF_DEF_DEPTH    = 32;
    localparam int RF_DEF_NREAD    = 2;
    localparam int RF_DEF_NWRITE   = 2;
    localparam int RF_DEF_ZERO_REG = 1;

    localparam int RF_MAX_WIDTH = 512;
    localparam int RF_MAX_NB    = RF_MAX_WIDTH / 8;

    localparam logic [RF_MAX_WIDTH-1:0] RF_RESET_VAL = '0;

    function automatic logic [RF_MAX_WIDTH-1:0] byte_merge(
        input logic [RF_MAX_WIDTH-1:0] old_w,
        input logic [RF_MAX_WIDTH-1:0] new_w,
        input logic [RF_MAX_NB-1:0]    mask
    );
        logic [RF_MAX_WIDTH-1:0] res;
        for (int b = 0; b < RF_MAX_NB; b++) begin
            res[b*8 +: 8] = mask[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_mp_wmerge.sv
// Per-byte write resolution for one target address across all write ports.
// Ports are scanned in ascending order, so the highest-index enabled port owns each byte.
module rf_mp_wmerge
    import rf_mp_pkg::*;
#(
    parameter  int WIDTH  = RF_DEF_WIDTH,
    parameter  int AW     = 5,
    parameter  int NWRITE = RF_DEF_NWRITE,
    localparam int NB     = WIDTH / 8
) (
    input  logic [AW-1:0]           addr,
    input  logic [NWRITE-1:0]       we,
    input  logic [NWRITE*AW-1:0]    wa,
    input  logic [NWRITE*NB-1:0]    wbe,
    input  logic [NWRITE*WIDTH-1:0] wd,
    output logic [NB-1:0]           hit,
    output logic [WIDTH-1:0]        data
);

    always_comb begin
        hit  = '0;
        data = '0;
        for (int p = 0; p < NWRITE; p++) begin
            if (we[p] && (wa[p*AW +: AW] == addr)) begin
                for (int b = 0; b < NB; b++) begin
                    if (wbe[p*NB + b]) begin
                        hit[b]          = 1'b1;
                        data[b*8 +: 8]  = wd[p*WIDTH + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/rf_mp.sv
// Parametrised multi-port flop register file with byte enables and async clear.
// Define RF_MP_BYPASS_EN to forward same-cycle write bytes onto the read ports.
module rf_mp
    import rf_mp_pkg::*;
#(
    parameter  int WIDTH    = RF_DEF_WIDTH,
    parameter  int DEPTH    = RF_DEF_DEPTH,
    parameter  int NREAD    = RF_DEF_NREAD,
    parameter  int NWRITE   = RF_DEF_NWRITE,
    parameter  int ZERO_REG = RF_DEF_ZERO_REG,
    localparam int AW       = $clog2(DEPTH),
    localparam int NB       = WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NWRITE-1:0]       we,
    input  logic [NWRITE*AW-1:0]    wa,
    input  logic [NWRITE*NB-1:0]    wbe,
    input  logic [NWRITE*WIDTH-1:0] wd,
    input  logic [NREAD*AW-1:0]     ra,
    output logic [NREAD*WIDTH-1:0]  rd
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];

    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
            assign nxt[r] = RF_RESET_VAL[WIDTH-1:0];
        end else begin : g_store
            logic [NB-1:0]                hit;
            logic [WIDTH-1:0]             data;
            logic [RF_MAX_WIDTH-WIDTH-1:0] unused_hi;

            rf_mp_wmerge #(
                .WIDTH  (WIDTH),
                .AW     (AW),
                .NWRITE (NWRITE)
            ) u_wmerge (
                .addr (AW'(r)),
                .we   (we),
                .wa   (wa),
                .wbe  (wbe),
                .wd   (wd),
                .hit  (hit),
                .data (data)
            );

            assign {unused_hi, nxt[r]} = byte_merge(RF_MAX_WIDTH'(mem[r]),
                                                    RF_MAX_WIDTH'(data),
                                                    RF_MAX_NB'(hit));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RF_RESET_VAL[WIDTH-1:0];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= nxt[i];
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    a;
        logic             blocked;
        logic [WIDTH-1:0] stored;

        assign a       = ra[i*AW +: AW];
        // Reset and the hardwired zero register both force the port to zero, bypass included.
        assign blocked = !reset_n || ((ZERO_REG != 0) && (a == '0));
        assign stored  = blocked ? '0 : mem[a];

`ifdef RF_MP_BYPASS_EN
        logic [NB-1:0]                 bhit;
        logic [WIDTH-1:0]              bdata;
        logic [WIDTH-1:0]              fwd;
        logic [RF_MAX_WIDTH-WIDTH-1:0] unused_hi;

        rf_mp_wmerge #(
            .WIDTH  (WIDTH),
            .AW     (AW),
            .NWRITE (NWRITE)
        ) u_bypass (
            .addr (a),
            .we   (we),
            .wa   (wa),
            .wbe  (wbe),
            .wd   (wd),
            .hit  (bhit),
            .data (bdata)
        );

        assign {unused_hi, fwd} = byte_merge(RF_MAX_WIDTH'(stored),
                                             RF_MAX_WIDTH'(bdata),
                                             RF_MAX_NB'(bhit));
        assign rd[i*WIDTH +: WIDTH] = blocked ? '0 : fwd;
`else
        assign rd[i*WIDTH +: WIDTH] = stored;
`endif
    end

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: default, ZERO_REG=0 and a 64x16/3R/1W instance checked against array models.
module tb_rf_mp;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   we;
    logic [9:0]   wa;
    logic [7:0]   wbe;
    logic [63:0]  wd;
    logic [9:0]   ra;
    logic [63:0]  rd0;
    logic [63:0]  rd1;

    logic         we2;
    logic [3:0]   wa2;
    logic [7:0]   wbe2;
    logic [63:0]  wd2;
    logic [11:0]  ra2;
    logic [191:0] rd2;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    logic [31:0] m0 [32];
    logic [31:0] m1 [32];
    logic [63:0] m2 [16];

    always #5 clk = ~clk;

    rf_mp dut0 (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wbe(wbe), .wd(wd), .ra(ra), .rd(rd0)
    );

    rf_mp #(.ZERO_REG(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wbe(wbe), .wd(wd), .ra(ra), .rd(rd1)
    );

    rf_mp #(.WIDTH(64), .DEPTH(16), .NREAD(3), .NWRITE(1), .ZERO_REG(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .we(we2), .wa(wa2), .wbe(wbe2), .wd(wd2), .ra(ra2), .rd(rd2)
    );

    // Register a with all of this cycle's enabled write bytes applied, later ports last.
    function automatic logic [31:0] pend(input logic [31:0] base, input int a);
        logic [31:0] v;
        v = base;
        for (int p = 0; p < 2; p++)
            if (we[p] && int'(wa[p*5 +: 5]) == a)
                for (int b = 0; b < 4; b++)
                    if (wbe[p*4 + b]) v[b*8 +: 8] = wd[p*32 + b*8 +: 8];
        return v;
    endfunction

    function automatic logic [63:0] pend2(input logic [63:0] base, input int a);
        logic [63:0] v;
        v = base;
        if (we2 && int'(wa2) == a)
            for (int b = 0; b < 8; b++)
                if (wbe2[b]) v[b*8 +: 8] = wd2[b*8 +: 8];
        return v;
    endfunction

    function automatic logic [31:0] exp01(input bit zr, input int a);
        logic [31:0] v;
        if (!reset_n) return 32'h0;
        if (zr && a == 0) return 32'h0;
        v = zr ? m0[a] : m1[a];
`ifdef RF_MP_BYPASS_EN
        v = pend(v, a);
`endif
        return v;
    endfunction

    function automatic logic [63:0] exp2(input int a);
        logic [63:0] v;
        if (!reset_n) return 64'h0;
        v = m2[a];
`ifdef RF_MP_BYPASS_EN
        v = pend2(v, a);
`endif
        return v;
    endfunction

    function automatic logic [63:0] pat(input int i);
        return 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h0101_0101_0101_0101;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int a;
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin m0[i] = '0; m1[i] = '0; end
            for (int i = 0; i < 16; i++) m2[i] = '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (we[p]) begin
                    a = int'(wa[p*5 +: 5]);
                    if (a != 0) m0[a] = pend(m0[a], a);
                    m1[a] = pend(m1[a], a);
                end
            end
            if (we2) begin
                a = int'(wa2);
                m2[a] = pend2(m2[a], a);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_rd0[%0d]", i), 64'(rd0[i*32 +: 32]), 64'(exp01(1'b1, int'(ra[i*5 +: 5]))));
                chk($sformatf("model_rd1[%0d]", i), 64'(rd1[i*32 +: 32]), 64'(exp01(1'b0, int'(ra[i*5 +: 5]))));
            end
            for (int i = 0; i < 3; i++)
                chk($sformatf("model_rd2[%0d]", i), rd2[i*64 +: 64], exp2(int'(ra2[i*4 +: 4])));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input int a, input logic [3:0] be, input logic [31:0] d);
        we[p]          = 1'b1;
        wa[p*5 +: 5]   = 5'(a);
        wbe[p*4 +: 4]  = be;
        wd[p*32 +: 32] = d;
    endtask

    task automatic rdaddr(input int a0, input int a1);
        ra = {5'(a1), 5'(a0)};
    endtask

    task automatic idle();
        we  = '0;
        wbe = '0;
    endtask

    initial begin
        logic [31:0] pre;
        we = '0; wa = '0; wbe = '0; wd = '0; ra = '0;
        we2 = 1'b0; wa2 = '0; wbe2 = '0; wd2 = '0; ra2 = '0;
        for (int i = 0; i < 32; i++) begin m0[i] = '0; m1[i] = '0; end
        for (int i = 0; i < 16; i++) m2[i] = '0;
        run = 1'b1;

        rdaddr(3, 6);
        step(); step();
        #2 chk("reset_rd0", rd0, 64'h0);
        step();
        reset_n = 1'b1;

        wr(0, 6, 4'hF, 32'h0000_00CA);
        rdaddr(6, 6);
`ifdef RF_MP_BYPASS_EN
        pre = 32'h0000_00CA;
`else
        pre = 32'h0;
`endif
        #2 chk("basic_pre_edge", 64'(rd0[31:0]), 64'(pre));
        step(); idle();
        #2 chk("basic_rd0", rd0, 64'h0000_00CA_0000_00CA);
        chk("basic_rd1", 64'(rd1[31:0]), 64'h0000_00CA);

        wr(0, 0, 4'hF, 32'h0000_000D);
        rdaddr(0, 0);
        step(); idle();
        #2 chk("zero_reg_on", rd0, 64'h0);
        chk("zero_reg_off", rd1, 64'h0000_000D_0000_000D);

        wr(0, 2, 4'hF, 32'hFFFF_FFFF);
        step();
        wr(0, 2, 4'b0101, 32'h1234_5678);
        step(); idle();
        rdaddr(2, 2);
        #2 chk("byte_enable", 64'(rd0[63:32]), 64'hFF34_FF78);

        wr(0, 4, 4'hF, 32'hAAAA_AAAA);
        wr(1, 4, 4'b0011, 32'h5555_5555);
        step(); idle();
        rdaddr(4, 4);
        #2 chk("conflict", 64'(rd0[31:0]), 64'hAAAA_5555);

        wr(0, 5, 4'b1100, 32'h1122_3344);
        wr(1, 5, 4'b0011, 32'h5566_7788);
        step(); idle();
        rdaddr(5, 4);
        #2 chk("disjoint", 64'(rd0[31:0]), 64'h1122_7788);
        wr(1, 5, 4'b0000, 32'hFFFF_FFFF);
        step(); idle();
        #2 chk("noop_wbe0", 64'(rd0[31:0]), 64'h1122_7788);

        wr(0, 1, 4'hF, 32'h0000_000C);
        wr(1, 4, 4'hF, 32'h0000_000A);
        step(); idle();
        rdaddr(1, 4);
        #2 chk("pre_reset", rd0, 64'h0000_000A_0000_000C);
        step();
        wr(0, 7, 4'hF, 32'h0000_0077);
        reset_n = 1'b0;
        #2 chk("reset_async", rd0, 64'h0);
        chk("reset_async_dut1", rd1, 64'h0);
        step(); step();
        reset_n = 1'b1;
        idle();
        rdaddr(7, 1);
        #2 chk("held_write_lost", rd1, 64'h0);
        rdaddr(4, 1);
        #2 chk("cleared_r4_r1", rd0, 64'h0);
        wr(0, 3, 4'hF, 32'h0000_0033);
        step(); idle();
        rdaddr(3, 3);
        #2 chk("write_after_reset", rd0, 64'h0000_0033_0000_0033);

        for (int i = 0; i < 16; i++) begin
            we2 = 1'b1; wa2 = 4'(i); wbe2 = 8'hFF; wd2 = pat(i);
            step();
        end
        we2 = 1'b0; wbe2 = '0;
        for (int i = 0; i < 16; i++) begin
            ra2 = {4'((i + 11) % 16), 4'((i + 5) % 16), 4'(i)};
            #2;
            chk($sformatf("sweep_p0_r%0d", i), rd2[63:0],    pat(i));
            chk($sformatf("sweep_p1_r%0d", i), rd2[127:64],  pat((i + 5) % 16));
            chk($sformatf("sweep_p2_r%0d", i), rd2[191:128], pat((i + 11) % 16));
            step();
        end
        ra2 = {4'd0, 4'd15, 4'd3};
        #2 chk("sweep_literal_r3", rd2[63:0], 64'h0426_486A_8CAE_D0F2);
        chk("sweep_literal_r15", rd2[127:64], 64'h1032_5476_98BA_DCFE);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
